// File: rtl/reg_file_tagged.sv
// Architectural register file with per-register busy bit and producing ROB tag.
// Optional commit-to-read bypass is enabled by defining REGFILE_CMT_BYPASS_EN.
module reg_file_tagged #(
   parameter  int XLEN  = 32,
   parameter  int NREG  = 32,
   parameter  int NRD   = 3,
   parameter  int TAG_W = 4,
   localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rdy_in,
   input  logic [NRD-1:0]        rd_valid_in,
   input  logic [NRD*AW-1:0]     rd_addr_in,
   output logic [NRD-1:0]        rd_ack_out,
   output logic [NRD*XLEN-1:0]   rd_data_out,
   output logic [NRD-1:0]        rd_busy_out,
   output logic [NRD*TAG_W-1:0]  rd_tag_out,
   input  logic                  iss_valid_in,
   input  logic [AW-1:0]         iss_rd_in,
   input  logic [TAG_W-1:0]      iss_tag_in,
   input  logic                  cmt_valid_in,
   input  logic [AW-1:0]         cmt_rd_in,
   input  logic [TAG_W-1:0]      cmt_tag_in,
   input  logic [XLEN-1:0]       cmt_data_in,
   input  logic                  flush_in
);

   logic [XLEN-1:0]  data_q [NREG];
   logic [TAG_W-1:0] tag_q  [NREG];
   logic [NREG-1:0]  busy_q;

   logic [NRD-1:0][AW-1:0]    rd_addr;
   logic [NRD-1:0][XLEN-1:0]  rd_data_d,  rd_data_q;
   logic [NRD-1:0][TAG_W-1:0] rd_tag_d,   rd_tag_q;
   logic [NRD-1:0]            rd_busy_d,  rd_busy_q;
   logic [NRD-1:0]            rd_ack_q;

   logic cmt_en, cmt_hit, iss_en, flush_en;

   assign rd_addr  = rd_addr_in;
   assign cmt_en   = rdy_in && cmt_valid_in && (cmt_rd_in != '0);
   // A commit only retires the register if no younger rename has replaced its tag.
   assign cmt_hit  = cmt_en && (tag_q[cmt_rd_in] == cmt_tag_in);
   assign flush_en = rdy_in && flush_in;
   assign iss_en   = rdy_in && iss_valid_in && (iss_rd_in != '0) && !flush_in;

   // NOTE: the register array is reset in full because every entry must read as
   // zero after reset; this keeps it out of plain RAM inference on purpose.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int r = 0; r < NREG; r++) begin
            data_q[r] <= '0;
            tag_q[r]  <= '0;
         end
         busy_q <= '0;
      end else begin
         // Entry 0 is never written, so it keeps its reset value of zero.
         for (int r = 1; r < NREG; r++) begin
            if (cmt_en && (cmt_rd_in == AW'(r)))
               data_q[r] <= cmt_data_in;
            if (flush_en) begin
               busy_q[r] <= 1'b0;
            end else if (iss_en && (iss_rd_in == AW'(r))) begin
               busy_q[r] <= 1'b1;
               tag_q[r]  <= iss_tag_in;
            end else if (cmt_hit && (cmt_rd_in == AW'(r))) begin
               busy_q[r] <= 1'b0;
            end
         end
      end
   end

   // NOTE: every output of this block gets a default before any condition, so
   // no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rd_data_d[i] = data_q[rd_addr[i]];
         rd_busy_d[i] = busy_q[rd_addr[i]];
         rd_tag_d[i]  = tag_q[rd_addr[i]];
`ifdef REGFILE_CMT_BYPASS_EN
         if (cmt_en && (cmt_rd_in == rd_addr[i])) begin
            rd_data_d[i] = cmt_data_in;
            if (cmt_hit)
               rd_busy_d[i] = 1'b0;
         end
`endif
         if (rd_addr[i] == '0) begin
            rd_data_d[i] = '0;
            rd_busy_d[i] = 1'b0;
            rd_tag_d[i]  = '0;
         end
      end
   end

   // Read responses land one cycle after the request; idle ports hold their last value.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_ack_q  <= '0;
         rd_data_q <= '0;
         rd_busy_q <= '0;
         rd_tag_q  <= '0;
      end else begin
         for (int i = 0; i < NRD; i++) begin
            if (rdy_in && rd_valid_in[i]) begin
               rd_ack_q[i]  <= 1'b1;
               rd_data_q[i] <= rd_data_d[i];
               rd_busy_q[i] <= rd_busy_d[i];
               rd_tag_q[i]  <= rd_tag_d[i];
            end else begin
               rd_ack_q[i]  <= 1'b0;
            end
         end
      end
   end

   assign rd_ack_out  = rd_ack_q;
   assign rd_data_out = rd_data_q;
   assign rd_busy_out = rd_busy_q;
   assign rd_tag_out  = rd_tag_q;

endmodule

// File: tb/tb_reg_file_tagged.sv
// Self-checking bench for reg_file_tagged: directed scenarios plus random traffic
// compared every cycle against a rule-level register-file model.
module tb_reg_file_tagged;
   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int NRD   = 3;
   localparam int TAG_W = 4;
   localparam int AW    = 5;

   logic                 clk_in = 1'b0;
   logic                 rst_n_in;
   logic                 rdy_in;
   logic [NRD-1:0]       rd_valid_in;
   logic [NRD*AW-1:0]    rd_addr_in;
   logic [NRD-1:0]       rd_ack_out;
   logic [NRD*XLEN-1:0]  rd_data_out;
   logic [NRD-1:0]       rd_busy_out;
   logic [NRD*TAG_W-1:0] rd_tag_out;
   logic                 iss_valid_in;
   logic [AW-1:0]        iss_rd_in;
   logic [TAG_W-1:0]     iss_tag_in;
   logic                 cmt_valid_in;
   logic [AW-1:0]        cmt_rd_in;
   logic [TAG_W-1:0]     cmt_tag_in;
   logic [XLEN-1:0]      cmt_data_in;
   logic                 flush_in;

   reg_file_tagged #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .TAG_W(TAG_W)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .rd_valid_in(rd_valid_in), .rd_addr_in(rd_addr_in),
      .rd_ack_out(rd_ack_out), .rd_data_out(rd_data_out),
      .rd_busy_out(rd_busy_out), .rd_tag_out(rd_tag_out),
      .iss_valid_in(iss_valid_in), .iss_rd_in(iss_rd_in), .iss_tag_in(iss_tag_in),
      .cmt_valid_in(cmt_valid_in), .cmt_rd_in(cmt_rd_in), .cmt_tag_in(cmt_tag_in),
      .cmt_data_in(cmt_data_in), .flush_in(flush_in)
   );

   always #5 clk_in = ~clk_in;

   // Reference model state and expected port outputs.
   logic [XLEN-1:0]  m_data [NREG];
   logic             m_busy [NREG];
   logic [TAG_W-1:0] m_tag  [NREG];
   logic             e_ack  [NRD];
   logic [XLEN-1:0]  e_data [NRD];
   logic             e_busy [NRD];
   logic [TAG_W-1:0] e_tag  [NRD];

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NREG; r++) begin
         m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
      end
      for (int i = 0; i < NRD; i++) begin
         e_ack[i] = 1'b0; e_data[i] = '0; e_busy[i] = 1'b0; e_tag[i] = '0;
      end
   endtask

   // Apply one clock of the register-file rules to the model.
   task automatic model_step();
      int a, c, w;
      for (int i = 0; i < NRD; i++) begin
         e_ack[i] = rdy_in && rd_valid_in[i];
         if (e_ack[i]) begin
            a = int'(rd_addr_in[i*AW +: AW]);
            e_data[i] = (a == 0) ? '0 : m_data[a];
            e_busy[i] = (a == 0) ? 1'b0 : m_busy[a];
            e_tag[i]  = (a == 0) ? '0 : m_tag[a];
`ifdef REGFILE_CMT_BYPASS_EN
            if (a != 0 && cmt_valid_in && int'(cmt_rd_in) == a) begin
               e_data[i] = cmt_data_in;
               if (m_tag[a] == cmt_tag_in) e_busy[i] = 1'b0;
            end
`endif
         end
      end
      if (rdy_in) begin
         c = int'(cmt_rd_in);
         w = int'(iss_rd_in);
         if (cmt_valid_in && c != 0) begin
            m_data[c] = cmt_data_in;
            if (m_tag[c] == cmt_tag_in) m_busy[c] = 1'b0;
         end
         if (flush_in) begin
            for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
         end else if (iss_valid_in && w != 0) begin
            m_busy[w] = 1'b1;
            m_tag[w]  = iss_tag_in;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < NRD; i++) begin
         check($sformatf("p%0d_ack", i),  64'(rd_ack_out[i]), 64'(e_ack[i]));
         check($sformatf("p%0d_data", i), 64'(rd_data_out[i*XLEN +: XLEN]), 64'(e_data[i]));
         check($sformatf("p%0d_busy", i), 64'(rd_busy_out[i]), 64'(e_busy[i]));
         check($sformatf("p%0d_tag", i),  64'(rd_tag_out[i*TAG_W +: TAG_W]), 64'(e_tag[i]));
      end
   endtask

   task automatic clr();
      rdy_in = 1'b1; rd_valid_in = '0; rd_addr_in = '0;
      iss_valid_in = 1'b0; iss_rd_in = '0; iss_tag_in = '0;
      cmt_valid_in = 1'b0; cmt_rd_in = '0; cmt_tag_in = '0; cmt_data_in = '0;
      flush_in = 1'b0;
   endtask

   task automatic step();
      model_step();
      @(posedge clk_in);
      #1;
      compare_all();
      clr();
   endtask

   task automatic rd(input int port, input int addr);
      rd_valid_in[port] = 1'b1;
      rd_addr_in[port*AW +: AW] = AW'(addr);
   endtask

   task automatic iss(input int r, input int t);
      iss_valid_in = 1'b1; iss_rd_in = AW'(r); iss_tag_in = TAG_W'(t);
   endtask

   task automatic cmt(input int r, input int t, input logic [XLEN-1:0] d);
      cmt_valid_in = 1'b1; cmt_rd_in = AW'(r); cmt_tag_in = TAG_W'(t); cmt_data_in = d;
   endtask

   initial begin
      clr();
      model_reset();
      rst_n_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      compare_all();
      @(negedge clk_in);
      rst_n_in = 1'b1;

      // Read x5 on all ports right after reset.
      for (int i = 0; i < NRD; i++) rd(i, 5);
      step();
      check("x5_ack_all", 64'(rd_ack_out), 64'h7);
      check("x5_data", 64'(rd_data_out[0 +: XLEN]), 64'h0);
      step();

      // Issue then commit with matching tag retires the register.
      iss(7, 3); step();
      cmt(7, 3, 32'hDEADBEEF); step();
      rd(1, 7); step();
      check("x7_commit_data", 64'(rd_data_out[XLEN +: XLEN]), 64'hDEADBEEF);
      check("x7_commit_busy", 64'(rd_busy_out[1]), 64'h0);

      // Stale commit writes data but leaves the younger rename pending.
      iss(7, 3); step();
      iss(7, 9); step();
      cmt(7, 3, 32'h11); step();
      rd(2, 7); step();
      check("x7_stale_data", 64'(rd_data_out[2*XLEN +: XLEN]), 64'h11);
      check("x7_stale_busy", 64'(rd_busy_out[2]), 64'h1);
      check("x7_stale_tag",  64'(rd_tag_out[2*TAG_W +: TAG_W]), 64'h9);

      // Same-cycle issue and commit, then flush.
      iss(4, 5); cmt(4, 0, 32'h22); step();
      rd(0, 4); step();
      check("x4_iss_cmt_data", 64'(rd_data_out[0 +: XLEN]), 64'h22);
      check("x4_iss_cmt_busy", 64'(rd_busy_out[0]), 64'h1);
      flush_in = 1'b1; step();
      rd(0, 4); step();
      check("x4_flush_busy", 64'(rd_busy_out[0]), 64'h0);
      check("x4_flush_data", 64'(rd_data_out[0 +: XLEN]), 64'h22);

      // Register zero is constant; same-cycle commit and read of x3.
      cmt(0, 0, 32'h55); step();
      rd(0, 0); step();
      check("x0_data", 64'(rd_data_out[0 +: XLEN]), 64'h0);
      cmt(3, 0, 32'h33); step();
      cmt(3, 0, 32'h99); rd(0, 3); step();
`ifdef REGFILE_CMT_BYPASS_EN
      check("x3_bypass_data", 64'(rd_data_out[0 +: XLEN]), 64'h99);
`else
      check("x3_nobypass_data", 64'(rd_data_out[0 +: XLEN]), 64'h33);
`endif
      rd(0, 3); step();
      check("x3_after_data", 64'(rd_data_out[0 +: XLEN]), 64'h99);

      // Stall: requests and issue ignored.
      rdy_in = 1'b0; iss(2, 1); rd(0, 2); rd(1, 2); step();
      check("stall_ack", 64'(rd_ack_out), 64'h0);
      rd(0, 2); step();
      check("x2_stall_busy", 64'(rd_busy_out[0]), 64'h0);

      // Flush drops a same-cycle issue.
      iss(9, 6); flush_in = 1'b1; step();
      rd(1, 9); step();
      check("x9_flush_iss_busy", 64'(rd_busy_out[1]), 64'h0);

      // Reset with a read in flight: no ack after release.
      iss(6, 2); step();
      for (int i = 0; i < NRD; i++) rd(i, 6);
      @(negedge clk_in);
      rst_n_in = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(posedge clk_in);
      #1;
      compare_all();
      @(negedge clk_in);
      rst_n_in = 1'b1;
      clr();
      step();
      check("post_reset_ack", 64'(rd_ack_out), 64'h0);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         rdy_in       = ($urandom_range(0, 9) != 0);
         rd_valid_in  = NRD'($urandom);
         for (int i = 0; i < NRD; i++)
            rd_addr_in[i*AW +: AW] = AW'($urandom_range(0, 7));
         iss_valid_in = $urandom_range(0, 1) != 0;
         iss_rd_in    = AW'($urandom_range(0, 7));
         iss_tag_in   = TAG_W'($urandom_range(0, 3));
         cmt_valid_in = $urandom_range(0, 1) != 0;
         cmt_rd_in    = AW'($urandom_range(0, 7));
         cmt_tag_in   = TAG_W'($urandom_range(0, 3));
         cmt_data_in  = XLEN'($urandom);
         flush_in     = ($urandom_range(0, 19) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
